// File: rtl/conv_result_framer.sv
// Frames filtered convolution pixels: optional binarisation, row/frame end tagging,
// and a first-word fall-through FIFO with a valid/ready handshake toward the image writer.
module conv_result_framer #(
  parameter int IM_SIZE    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       thresh_en,
  input  logic [7:0] threshold,
  input  logic [7:0] data_i,
  input  logic       data_write,
  output logic [7:0] pix_o,
  output logic       pix_eol,
  output logic       pix_eof,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       overflow,
  output logic       busy,
  output logic       frame_done
);

  localparam int OUT_DIM = IM_SIZE - 2;
  localparam int CW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(OUT_DIM - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, row;
  logic          thresh_en_q;
  logic [7:0]    threshold_q;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic       start_ok, capture, full, empty, push, pop, eol, eof;
  logic [7:0] pix_val;
  logic [9:0] head;

  assign start_ok = (state == IDLE) && frame_start;
  assign capture  = (state == RUN) && data_write;
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign pop      = !empty && pix_ready;
  // A full FIFO still takes a pixel when the head leaves in the same cycle.
  assign push     = capture && (!full || pop);
  assign eol      = (col == LAST_IDX);
  assign eof      = eol && (row == LAST_IDX);
  assign pix_val  = thresh_en_q ? ((data_i >= threshold_q) ? 8'hFF : 8'h00) : data_i;

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = RUN;
      RUN:     if (capture && eof) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      overflow    <= 1'b0;
      thresh_en_q <= 1'b0;
      threshold_q <= '0;
    end else if (start_ok) begin
      col         <= '0;
      row         <= '0;
      overflow    <= 1'b0;
      thresh_en_q <= thresh_en;
      threshold_q <= threshold;
    end else if (capture) begin
      // Position advances even for dropped pixels so tags stay aligned and the frame ends.
      if (eol) begin
        col <= '0;
        row <= eof ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if (full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; outputs are gated by pix_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {eof, eol, pix_val};
  end

  assign head       = mem[rd_ptr];
  assign pix_valid  = !empty;
  assign pix_o      = pix_valid ? head[7:0] : 8'h00;
  assign pix_eol    = pix_valid && head[8];
  assign pix_eof    = pix_valid && head[9];
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule
